// File: rtl/control_unit_if.sv
// Bus-and-tag link between a channel (master) and a device control unit (slave).
// Outbound tags travel channel-to-device and inbound tags travel device-to-channel.
interface control_unit_if;
    logic [7:0] bus_out;
    logic       operational_out;
    logic       hold_out;
    logic       select_out;
    logic       address_out;
    logic       command_out;
    logic       service_out;
    logic       suppress_out;
    logic [7:0] bus_in;
    logic       operational_in;
    logic       select_in;
    logic       address_in;
    logic       status_in;
    logic       service_in;
    logic       request_in;

    modport master (
        output bus_out, operational_out, hold_out, select_out, address_out,
               command_out, service_out, suppress_out,
        input  bus_in, operational_in, select_in, address_in, status_in,
               service_in, request_in
    );

    modport slave (
        input  bus_out, operational_out, hold_out, select_out, address_out,
               command_out, service_out, suppress_out,
        output bus_in, operational_in, select_in, address_in, status_in,
               service_in, request_in
    );
endinterface

// File: rtl/control_unit.sv
// Single-address device control unit: selection, command, initial status,
// interlocked byte transfer and ending status on the bus-and-tag link.
module control_unit #(
    parameter logic [7:0] ADDRESS = 8'h10
) (
    input  logic           clk,
    input  logic           reset_n,
    control_unit_if.slave  chan,
    input  logic           busy,
    input  logic [7:0]     xfer_length,
    input  logic [7:0]     rd_data,
    output logic [7:0]     cmd,
    output logic           cmd_strobe,
    output logic [7:0]     wr_data,
    output logic           data_strobe,
    output logic [7:0]     byte_count
);
    typedef enum logic [3:0] {
        IDLE, PROPAGATE, SELECT, ADDR_IN, CMD_WAIT, STATUS, STATUS_WAIT,
        DATA, DATA_WAIT, STOP_WAIT, ENDING, END_WAIT, DISCONNECT
    } state_t;

    state_t     state;
    logic [7:0] status;
    logic [7:0] length;

    logic unused_tags;
    assign unused_tags     = chan.hold_out ^ chan.suppress_out;
    assign chan.request_in = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset_n || !chan.operational_out) begin
            state               <= IDLE;
            status              <= 8'h00;
            length              <= 8'h00;
            cmd                 <= 8'h00;
            cmd_strobe          <= 1'b0;
            wr_data             <= 8'h00;
            data_strobe         <= 1'b0;
            byte_count          <= 8'h00;
            chan.bus_in         <= 8'h00;
            chan.operational_in <= 1'b0;
            chan.select_in      <= 1'b0;
            chan.address_in     <= 1'b0;
            chan.status_in      <= 1'b0;
            chan.service_in     <= 1'b0;
        end else begin
            cmd_strobe  <= 1'b0;
            data_strobe <= 1'b0;

            // Tags are registered from the current state, so each response lags its cause by one clock
            chan.operational_in <= state inside {SELECT, ADDR_IN, CMD_WAIT, STATUS, STATUS_WAIT,
                                                 DATA, DATA_WAIT, STOP_WAIT, ENDING, END_WAIT};
            chan.select_in      <= (state == PROPAGATE) && chan.select_out;
            chan.address_in     <= (state == ADDR_IN);
            chan.status_in      <= (state == STATUS) || (state == ENDING);
            chan.service_in     <= (state == DATA);

            case (state)
                ADDR_IN: chan.bus_in <= ADDRESS;
                STATUS:  chan.bus_in <= status;
                // rd_data is taken only as service_in rises, then held for the whole handshake
                DATA:    if (!chan.service_in) chan.bus_in <= cmd[0] ? 8'h00 : rd_data;
                ENDING:  chan.bus_in <= 8'h0C;
                default: chan.bus_in <= 8'h00;
            endcase

            case (state)
                IDLE:
                    if (chan.select_out && chan.address_out)
                        state <= (chan.bus_out == ADDRESS) ? SELECT : PROPAGATE;
                PROPAGATE:
                    if (!chan.select_out) state <= IDLE;
                SELECT:
                    if (!chan.address_out) state <= ADDR_IN;
                ADDR_IN:
                    if (chan.command_out) begin
                        cmd        <= chan.bus_out;
                        cmd_strobe <= 1'b1;
                        length     <= xfer_length;
                        byte_count <= 8'h00;
                        status     <= busy ? 8'h10 : 8'h00;
                        state      <= CMD_WAIT;
                    end
                CMD_WAIT:
                    if (!chan.command_out) state <= STATUS;
                STATUS:
                    if (chan.service_out) state <= STATUS_WAIT;
                STATUS_WAIT:
                    if (!chan.service_out) begin
                        if (status != 8'h00 || cmd == 8'h00) state <= DISCONNECT;
                        else if (length == 8'h00)            state <= ENDING;
                        else                                 state <= DATA;
                    end
                DATA:
                    // A stop from the channel takes priority over a concurrent byte handshake
                    if (chan.command_out) begin
                        state <= STOP_WAIT;
                    end else if (chan.service_out) begin
                        if (cmd[0]) wr_data <= chan.bus_out;
                        data_strobe <= 1'b1;
                        if (byte_count != 8'hFF) byte_count <= byte_count + 8'd1;
                        state <= DATA_WAIT;
                    end
                DATA_WAIT:
                    if (!chan.service_out) state <= (byte_count == length) ? ENDING : DATA;
                STOP_WAIT:
                    if (!chan.command_out) state <= ENDING;
                ENDING:
                    if (chan.service_out) state <= END_WAIT;
                END_WAIT:
                    if (!chan.service_out) state <= DISCONNECT;
                DISCONNECT:
                    state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the bench plays the channel side of the link
// and checks tags, bus values, strobes and counters against hand-computed vectors.
module tb_control_unit;
    localparam logic [7:0] ADDR = 8'h10;
    localparam int OPI = 0, SLI = 1, ADI = 2, STI = 3, SVI = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] xfer_length = 8'h00;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] cmd;
    logic       cmd_strobe;
    logic [7:0] wr_data;
    logic       data_strobe;
    logic [7:0] byte_count;

    control_unit_if bus_if();

    control_unit #(.ADDRESS(ADDR)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chan        (bus_if),
        .busy        (busy),
        .xfer_length (xfer_length),
        .rd_data     (rd_data),
        .cmd         (cmd),
        .cmd_strobe  (cmd_strobe),
        .wr_data     (wr_data),
        .data_strobe (data_strobe),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int strobe_cnt = 0;
    int cstrobe_cnt = 0;
    int op_cycles = 0;

    always @(negedge clk) begin
        if (data_strobe) strobe_cnt++;
        if (cmd_strobe) cstrobe_cnt++;
        if (bus_if.operational_in) op_cycles++;
    end

    typedef struct {
        logic [7:0] cmd;
        logic       busy;
        logic [7:0] len;
        logic [7:0] cnt;
        logic [7:0] rd;
        logic [7:0] stat;
        logic [7:0] strobes;
        logic [7:0] bytes;
        logic       end_st;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            OPI:     return bus_if.operational_in;
            SLI:     return bus_if.select_in;
            ADI:     return bus_if.address_in;
            STI:     return bus_if.status_in;
            SVI:     return bus_if.service_in;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int s, input logic lvl, input string name);
        bit ok = 0;
        n_vec++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sig(s) === lvl) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout %s: tag stayed %b expected %b", name, sig(s), lvl);
        end
    endtask

    task automatic wait_any(output logic is_svc, output bit ok);
        ok = 0;
        is_svc = 1'b0;
        n_vec++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_if.service_in || bus_if.status_in) begin
                ok = 1;
                is_svc = bus_if.service_in;
                break;
            end
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout data phase: got no tag expected service_in or status_in");
        end
    endtask

    task automatic idle_bus();
        bus_if.bus_out     = 8'h00;
        bus_if.hold_out    = 1'b0;
        bus_if.select_out  = 1'b0;
        bus_if.address_out = 1'b0;
        bus_if.command_out = 1'b0;
        bus_if.service_out = 1'b0;
    endtask

    // Selection, command and initial status; select/hold are dropped mid-way on purpose
    task automatic open_op(input logic [7:0] c, input logic [7:0] stat);
        bus_if.bus_out     = ADDR;
        bus_if.hold_out    = 1'b1;
        bus_if.select_out  = 1'b1;
        bus_if.address_out = 1'b1;
        wait_sig(OPI, 1'b1, "operational_in rise");
        bus_if.address_out = 1'b0;
        wait_sig(ADI, 1'b1, "address_in rise");
        check("address on bus_in", bus_if.bus_in, ADDR);
        bus_if.bus_out     = c;
        bus_if.command_out = 1'b1;
        wait_sig(ADI, 1'b0, "address_in drop");
        bus_if.command_out = 1'b0;
        bus_if.bus_out     = 8'h00;
        bus_if.select_out  = 1'b0;
        bus_if.hold_out    = 1'b0;
        wait_sig(STI, 1'b1, "initial status_in rise");
        check("initial status", bus_if.bus_in, stat);
        bus_if.service_out = 1'b1;
        wait_sig(STI, 1'b0, "initial status_in drop");
        bus_if.service_out = 1'b0;
    endtask

    task automatic byte_xfer(input logic [7:0] c, input logic [7:0] wval, input logic [7:0] rexp);
        if (c[0]) bus_if.bus_out = wval;
        else check("read byte on bus_in", bus_if.bus_in, rexp);
        bus_if.service_out = 1'b1;
        wait_sig(SVI, 1'b0, "service_in drop");
        bus_if.service_out = 1'b0;
        bus_if.bus_out     = 8'h00;
        if (c[0]) check("wr_data", wr_data, wval);
    endtask

    task automatic run_op(input vec_t v);
        int   s0 = strobe_cnt;
        int   c0 = cstrobe_cnt;
        int   nbytes = 0;
        bit   got_st = 0;
        bit   ok;
        logic is_svc;
        busy        = v.busy;
        xfer_length = v.len;
        rd_data     = v.rd;
        open_op(v.cmd, v.stat);
        if (v.stat == 8'h00 && v.cmd != 8'h00) begin
            for (int k = 0; k < 20; k++) begin
                wait_any(is_svc, ok);
                if (!ok) break;
                if (is_svc) begin
                    if (nbytes == int'(v.cnt)) begin
                        bus_if.command_out = 1'b1;
                        wait_sig(SVI, 1'b0, "service_in drop on stop");
                        bus_if.command_out = 1'b0;
                    end else begin
                        byte_xfer(v.cmd, v.cnt - 8'(nbytes), v.rd);
                        nbytes++;
                    end
                end else begin
                    check("ending status", bus_if.bus_in, 8'h0C);
                    bus_if.service_out = 1'b1;
                    wait_sig(STI, 1'b0, "ending status_in drop");
                    bus_if.service_out = 1'b0;
                    got_st = 1;
                    break;
                end
            end
        end
        check("ending status presented", {7'd0, got_st}, {7'd0, v.end_st});
        wait_sig(OPI, 1'b0, "operational_in drop");
        @(negedge clk);
        @(negedge clk);
        check("cmd", cmd, v.cmd);
        check("cmd_strobe pulses", 8'(cstrobe_cnt - c0), 8'd1);
        check("data_strobe pulses", 8'(strobe_cnt - s0), v.strobes);
        check("byte_count", byte_count, v.bytes);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bus_in"}, bus_if.bus_in, 8'h00);
        check({tag, " tags"}, {2'b00, bus_if.operational_in, bus_if.select_in, bus_if.address_in,
                               bus_if.status_in, bus_if.service_in, bus_if.request_in}, 8'h00);
        check({tag, " cmd"}, cmd, 8'h00);
        check({tag, " wr_data"}, wr_data, 8'h00);
        check({tag, " byte_count"}, byte_count, 8'h00);
        check({tag, " strobes"}, {6'd0, cmd_strobe, data_strobe}, 8'h00);
    endtask

    task automatic into_data();
        busy        = 1'b0;
        xfer_length = 8'd4;
        rd_data     = 8'h00;
        open_op(8'h01, 8'h00);
        wait_sig(SVI, 1'b1, "service_in first byte");
        byte_xfer(8'h01, 8'h5A, 8'h00);
        wait_sig(SVI, 1'b1, "service_in second byte");
        check("byte_count before reset", byte_count, 8'd1);
    endtask

    initial begin
        int op0;
        //            cmd    busy  len    cnt    rd     stat   strb   bytes  end
        vecs[0] = '{8'h00, 1'b0, 8'd0, 8'd0, 8'h00, 8'h00, 8'd0, 8'd0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 8'd3, 8'd3, 8'h00, 8'h00, 8'd3, 8'd3, 1'b1};
        vecs[2] = '{8'h02, 1'b0, 8'd5, 8'd2, 8'hA5, 8'h00, 8'd2, 8'd2, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 8'd3, 8'd3, 8'h00, 8'h10, 8'd0, 8'd0, 1'b0};
        vecs[4] = '{8'h05, 1'b0, 8'd0, 8'd4, 8'h00, 8'h00, 8'd0, 8'd0, 1'b1};
        vecs[5] = '{8'h04, 1'b0, 8'd2, 8'd6, 8'h3C, 8'h00, 8'd2, 8'd2, 1'b1};

        idle_bus();
        bus_if.operational_out = 1'b1;
        bus_if.suppress_out    = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");

        // Foreign address: select propagates, device never goes operational
        op0 = op_cycles;
        bus_if.bus_out     = 8'h22;
        bus_if.select_out  = 1'b1;
        bus_if.address_out = 1'b1;
        wait_sig(SLI, 1'b1, "select_in propagate");
        bus_if.select_out  = 1'b0;
        bus_if.address_out = 1'b0;
        bus_if.bus_out     = 8'h00;
        wait_sig(SLI, 1'b0, "select_in follow drop");
        repeat (2) @(negedge clk);
        check("operational_in cycles on mismatch", 8'(op_cycles - op0), 8'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
            idle_bus();
            repeat (2) @(negedge clk);
        end

        into_data();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_all_zero("reset_n in DATA");
        idle_bus();
        repeat (2) @(negedge clk);

        into_data();
        bus_if.operational_out = 1'b0;
        @(negedge clk);
        bus_if.operational_out = 1'b1;
        check_all_zero("operational_out low in DATA");
        idle_bus();
        repeat (2) @(negedge clk);

        run_op(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Device-side bus-and-tag responder that sits directly downstream of `channel`. It emulates a single-device control unit with a fixed address. It answers initial selection, accepts a command, presents initial status, and runs byte-by-byte data transfer in interlocked mode. It finishes with ending status. It serves as the bench partner for `channel` and later as the front end of real device emulation.

## Interface
- `ADDRESS`, default 8'h10: device address the unit responds to.
- `clk` input 1: sole clock; all state changes on rising edge.
- `reset_n` input 1: synchronous reset, active-low.
- `bus_out` input 8: channel data bus toward the device.
- `operational_out`, `hold_out`, `select_out`, `address_out`, `command_out`, `service_out`, `suppress_out` input 1 each: outbound tags from the channel. `suppress_out` is ignored.
- `bus_in` output 8: device data bus toward the channel.
- `operational_in`, `select_in`, `address_in`, `status_in`, `service_in`, `request_in` output 1 each: inbound tags. `request_in` is tied to 0.
- `busy` input 1: when high at command capture, initial status is busy (8'h10).
- `xfer_length` input 8: number of bytes the device transfers. Sampled at command capture.
- `rd_data` input 8: byte to send on read commands. Sampled when `service_in` rises.
- `cmd` output 8: last captured command. Holds its value until the next capture.
- `cmd_strobe` output 1: one-cycle pulse when `cmd` updates.
- `wr_data` output 8: byte received on write commands.
- `data_strobe` output 1: one-cycle pulse per accepted byte, for both read and write.
- `byte_count` output 8: bytes transferred in the current operation.

## Operation
- All outputs are registered. Reset value is 0 for every output, `cmd` and `byte_count` included, and the state returns to IDLE.
- Inputs are treated as synchronous to `clk`. Synchronisers live outside this block.
- `operational_out` low in any state acts as a selective reset: the block enters the reset state on the next edge.
- States:
  - IDLE:
    - On `select_out` & `address_out` & `bus_out`==ADDRESS: go to SELECT.
    - On `select_out` & `address_out` with any other address: go to PROPAGATE.
  - PROPAGATE: `select_in` follows `select_out`. When `select_out` falls, return to IDLE.
  - SELECT: raise `operational_in`, which stays high until DISCONNECT. Go to ADDR_IN once `address_out` is low.
  - ADDR_IN: `address_in`=1, `bus_in`=ADDRESS. On `command_out`:
    - Latch `cmd`=`bus_out`.
    - Pulse `cmd_strobe`.
    - Latch `xfer_length`.
    - Clear `byte_count`.
    - Set status to `busy` ? 8'h10 : 8'h00.
    - Go to CMD_WAIT.
  - CMD_WAIT: `address_in`=0. Go to STATUS when `command_out` falls.
  - STATUS: `status_in`=1, `bus_in`=status. On `service_out`, go to STATUS_WAIT.
  - STATUS_WAIT: `status_in`=0. When `service_out` falls:
    - If status≠0 or `cmd`==0, go to DISCONNECT.
    - Else if latched length is 0, go to ENDING.
    - Else go to DATA.
  - DATA: `service_in`=1. `bus_in`=`rd_data` when `cmd[0]`=0, else 0.
    - On `service_out`: capture `wr_data`=`bus_out` if `cmd[0]`=1, pulse `data_strobe`, increment `byte_count`, go to DATA_WAIT.
    - On `command_out` (stop): go to STOP_WAIT. `byte_count` is unchanged.
    - If `service_out` and `command_out` are both high, stop wins.
  - DATA_WAIT: `service_in`=0. When `service_out` falls, go to ENDING if `byte_count`==latched length, else DATA.
  - STOP_WAIT: `service_in`=0. When `command_out` falls, go to ENDING.
  - ENDING: `status_in`=1, `bus_in`=8'h0C (CE|DE). On `service_out`, go to END_WAIT.
  - END_WAIT: `status_in`=0. When `service_out` falls, go to DISCONNECT.
  - DISCONNECT: `operational_in`=0, then return to IDLE next cycle.
- `select_out` or `hold_out` dropping after selection does not end the operation.
- `byte_count` is 8-bit and saturates at 255. Its width matches `channel` `count`.

## Timing
- Every tag response follows the causing input edge by exactly 1 clk: the input is sampled on edge N and the output changes at edge N+1.
- `bus_in` changes on the same edge as its qualifying tag rises and is held stable while that tag is high.
- Each inbound tag drops 1 clk after the matching outbound tag rises. The next tag cannot rise until the outbound tag has been sampled low.
- `data_strobe` and `cmd_strobe` assert in the same cycle the block leaves DATA or ADDR_IN.
- There are no timeouts. The block waits indefinitely in any state.

## Test plan
- Address mismatch: channel selects address 8'h22 with ADDRESS=8'h10 → `select_in` rises, `channel` returns to IDLE, and `operational_in` stays 0 throughout.
- Test I/O: command 8'h00 → `channel` `status_strobe` with status 8'h00, `operational_in` drops, `channel` `active` falls, and `cmd_strobe` fires once.
- Write: command 8'h01, `channel` count 3, `xfer_length` 3 → three `data_strobe` pulses with `wr_data` 3, 2, 1, then ending status 8'h0C, and `byte_count`=3.
- Read stop: command 8'h02, count 2, `xfer_length` 5, `rd_data` 8'hA5 → two bytes, then stop via `command_out`, ending 8'h0C, and `byte_count`=2.
- Busy: `busy`=1 with command 8'h01 → initial status 8'h10, disconnect, and no `data_strobe`.
- Reset during DATA: `reset_n` low for 1 clk mid-transfer → every output reads 0 on the next cycle. The same applies when `operational_out` goes low.
